// File: rtl/sm_adder_table_writer_if.sv
// rtl/sm_adder_table_writer_if.sv - init handshake and a/b/sum lookup bundle for the run-time built adder table
interface sm_adder_table_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  init_start;
  logic                  init_busy;
  logic                  init_done;
  logic                  lkp_valid;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH:0]   sum;
  logic                  sum_valid;

  modport master (
    output init_start, lkp_valid, a, b,
    input  init_busy, init_done, sum, sum_valid
  );

  modport slave (
    input  init_start, lkp_valid, a, b,
    output init_busy, init_done, sum, sum_valid
  );
endinterface

// File: rtl/sm_adder_table_writer.sv
// rtl/sm_adder_table_writer.sv - fills a sign-magnitude sum table at run time, then serves 1-cycle lookups
// Optional read-back verification pass is enabled with TABLE_READBACK_CHECK_EN.
module sm_adder_table_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  sm_adder_table_writer_if.slave bus
`ifdef TABLE_READBACK_CHECK_EN
  ,
  output logic check_err
`endif
);

`ifdef TABLE_READBACK_CHECK_EN
  typedef enum logic [1:0] {IDLE, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy;
  logic                  done;
  logic                  start_acc;
  logic [DATA_WIDTH:0]   sum_q;
  logic                  sum_valid_q;
  logic [DATA_WIDTH:0]   mem [0:(2**ADDR_WIDTH)-1];

  // Address layout is {a, b}; the result is {sign, DATA_WIDTH-bit magnitude}, and zero is always +0.
  function automatic logic [DATA_WIDTH:0] sm_add(input logic [ADDR_WIDTH-1:0] addr);
    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    logic [DATA_WIDTH-1:0] mag;
    logic                  sgn;
    sa = addr[ADDR_WIDTH-1];
    ma = addr[ADDR_WIDTH-2 -: DATA_WIDTH-1];
    sb = addr[DATA_WIDTH-1];
    mb = addr[DATA_WIDTH-2:0];
    if (sa == sb) begin
      mag = {1'b0, ma} + {1'b0, mb};
      sgn = sa;
    end else if (ma >= mb) begin
      mag = {1'b0, ma - mb};
      sgn = sa;
    end else begin
      mag = {1'b0, mb - ma};
      sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

`ifdef TABLE_READBACK_CHECK_EN
  logic                chk_tail;
  logic                cmp_valid;
  logic [DATA_WIDTH:0] rd_data;
  logic [DATA_WIDTH:0] exp_q;
`endif

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    start_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.init_start) begin
          next_state = WRITE;
          start_acc  = 1'b1;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (cnt == CNT_MAX) begin
`ifdef TABLE_READBACK_CHECK_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef TABLE_READBACK_CHECK_EN
      CHECK: begin
        busy = 1'b1;
        if (chk_tail) next_state = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (bus.init_start) begin
          next_state = WRITE;
          start_acc  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state       <= next_state;
      if (start_acc) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      sum_valid_q <= done && bus.lkp_valid;
      if (done && bus.lkp_valid) sum_q <= mem[{bus.a, bus.b}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == WRITE) mem[cnt] <= sm_add(cnt);
  end

`ifdef TABLE_READBACK_CHECK_EN
  // Read and regenerate in lockstep; the compare lands one cycle later, hence the tail cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_tail  <= 1'b0;
      cmp_valid <= 1'b0;
      rd_data   <= '0;
      exp_q     <= '0;
      check_err <= 1'b0;
    end else begin
      chk_tail  <= (state == CHECK) && (cnt == CNT_MAX);
      cmp_valid <= (state == CHECK) && !chk_tail;
      rd_data   <= mem[cnt];
      exp_q     <= sm_add(cnt);
      if (start_acc) begin
        check_err <= 1'b0;
      end else if (cmp_valid && rd_data != exp_q) begin
        check_err <= 1'b1;
      end
    end
  end
`endif

  assign bus.init_busy = busy;
  assign bus.init_done = done;
  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;

endmodule

// File: tb/tb_sm_adder_table_writer.sv
// tb/tb_sm_adder_table_writer.sv - randomized self-checking bench for sm_adder_table_writer
// Build with TABLE_READBACK_CHECK_EN defined to also exercise the read-back pass.
module tb_sm_adder_table_writer;
  localparam int DW   = 8;
  localparam int FILL = 2 ** (2 * DW);
`ifdef TABLE_READBACK_CHECK_EN
  localparam int EXP_BUSY = FILL + FILL + 1;
`else
  localparam int EXP_BUSY = FILL;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DW:0] last_sum;

  sm_adder_table_writer_if #(.DATA_WIDTH(DW)) bus ();

`ifdef TABLE_READBACK_CHECK_EN
  logic check_err;
  sm_adder_table_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(2 * DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .check_err(check_err)
  );
`else
  sm_adder_table_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(2 * DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed-integer view of sign-magnitude addition.
  function automatic logic [DW:0] ref_sum(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int vx;
    int vy;
    int s;
    vx = int'(x[DW-2:0]);
    vy = int'(y[DW-2:0]);
    if (x[DW-1]) vx = -vx;
    if (y[DW-1]) vy = -vy;
    s = vx + vy;
    if (s < 0) return {1'b1, DW'(-s)};
    return {1'b0, DW'(s)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.init_start = 1'b0;
    bus.lkp_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    checks++;
    if (bus.init_busy !== 1'b0 || bus.init_done !== 1'b0 || bus.sum_valid !== 1'b0 || bus.sum !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum_valid=%b sum=%h, required all 0",
               bus.init_busy, bus.init_done, bus.sum_valid, bus.sum);
    end
`ifdef TABLE_READBACK_CHECK_EN
    checks++;
    if (check_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_check_err: got %b, required 0", check_err);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_fill;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    checks++;
    if (bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: got %b, required 1", bus.init_busy);
    end
    for (int i = 1; i < 1000; i++) begin
      bus.lkp_valid = 1'b1;
      bus.a = DW'($urandom);
      bus.b = DW'($urandom);
      tick();
      checks++;
      if (bus.sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL lookup_before_done: cycle %0d sum_valid=%b, required 0", i, bus.sum_valid);
      end
    end
    bus.lkp_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.init_busy !== 1'b0 || bus.init_done !== 1'b0 || bus.sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fill: busy=%b done=%b sum_valid=%b, required 0 0 0",
               bus.init_busy, bus.init_done, bus.sum_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.init_busy !== 1'b0 || bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.init_busy, bus.init_done);
    end
  endtask

  task automatic test_fill;
    int n;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 2 * EXP_BUSY + 10) begin
      n++;
      if (n < 200) begin
        checks++;
        if (bus.sum_valid !== 1'b0) begin
          errors++;
          $display("FAIL lookup_during_fill: cycle %0d sum_valid=%b, required 0", n, bus.sum_valid);
        end
      end
      bus.init_start = (n == 100);
      bus.lkp_valid = (n < 199);
      bus.a = DW'($urandom);
      bus.b = DW'($urandom);
      tick();
    end
    bus.init_start = 1'b0;
    bus.lkp_valid = 1'b0;
    checks++;
    if (n != EXP_BUSY) begin
      errors++;
      $display("FAIL fill_length: busy for %0d cycles, required %0d", n, EXP_BUSY);
    end
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("FAIL done_after_fill: got %b, required 1", bus.init_done);
    end
`ifdef TABLE_READBACK_CHECK_EN
    checks++;
    if (check_err !== 1'b0) begin
      errors++;
      $display("FAIL clean_check_err: got %b, required 0", check_err);
    end
`endif
  endtask

  task automatic test_directed;
    logic [DW-1:0] va [8];
    logic [DW-1:0] vb [8];
    logic [DW:0]   ve [8];
    va = '{8'h01, 8'h02, 8'h84, 8'h82, 8'hB9, 8'hFF, 8'h80, 8'h85};
    vb = '{8'h02, 8'h84, 8'h01, 8'h82, 8'h79, 8'hFF, 8'h00, 8'h05};
    ve = '{9'h003, 9'h102, 9'h103, 9'h104, 9'h040, 9'h1FE, 9'h000, 9'h000};
    for (int i = 0; i < 8; i++) begin
      bus.lkp_valid = 1'b1;
      bus.a = va[i];
      bus.b = vb[i];
      tick();
      checks++;
      if (bus.sum_valid !== 1'b1 || bus.sum !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d: a=%h b=%h sum_valid=%b sum=%h, required 1 %h",
                 i, va[i], vb[i], bus.sum_valid, bus.sum, ve[i]);
      end
    end
    last_sum = ve[7];
    bus.lkp_valid = 1'b0;
    tick();
    checks++;
    if (bus.sum_valid !== 1'b0 || bus.sum !== last_sum) begin
      errors++;
      $display("FAIL directed_hold: sum_valid=%b sum=%h, required 0 %h", bus.sum_valid, bus.sum, last_sum);
    end
  endtask

  task automatic test_back_to_back;
    logic v;
    logic [DW:0] exp_sum;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      bus.lkp_valid = v;
      bus.a = DW'($urandom);
      bus.b = DW'($urandom);
      if ($urandom_range(0, 7) == 0) bus.b = {~bus.a[DW-1], bus.a[DW-2:0]};
      exp_sum = v ? ref_sum(bus.a, bus.b) : last_sum;
      tick();
      checks++;
      if (bus.sum_valid !== v || bus.sum !== exp_sum) begin
        errors++;
        $display("FAIL random_lookup_%0d: sum_valid=%b sum=%h, required %b %h",
                 i, bus.sum_valid, bus.sum, v, exp_sum);
      end
      last_sum = exp_sum;
    end
    bus.lkp_valid = 1'b0;
    tick();
  endtask

  task automatic test_lookup_with_start;
    logic [DW:0] exp_sum;
    bus.lkp_valid = 1'b1;
    bus.init_start = 1'b1;
    bus.a = DW'($urandom);
    bus.b = DW'($urandom);
    exp_sum = ref_sum(bus.a, bus.b);
    tick();
    bus.lkp_valid = 1'b0;
    bus.init_start = 1'b0;
    checks++;
    if (bus.sum_valid !== 1'b1 || bus.sum !== exp_sum) begin
      errors++;
      $display("FAIL lookup_with_start: sum_valid=%b sum=%h, required 1 %h", bus.sum_valid, bus.sum, exp_sum);
    end
    checks++;
    if (bus.init_busy !== 1'b1 || bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_state: busy=%b done=%b, required 1 0", bus.init_busy, bus.init_done);
    end
`ifdef TABLE_READBACK_CHECK_EN
    begin
      int n;
      repeat (FILL) tick();
      dut.mem[16'h1234] = ~ref_sum(8'h12, 8'h34);
      n = 0;
      while (bus.init_done !== 1'b1 && n < 2 * EXP_BUSY) begin
        n++;
        tick();
      end
      checks++;
      if (bus.init_done !== 1'b1 || check_err !== 1'b1) begin
        errors++;
        $display("FAIL corrupt_detect: done=%b check_err=%b, required 1 1", bus.init_done, check_err);
      end
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_sum = '0;
    test_reset();
    test_reset_mid_fill();
    test_fill();
    test_directed();
    test_back_to_back();
    test_lookup_with_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
